// File: rtl/pbit_sched.sv
// Time-multiplexed p-bit scheduler: one shared MAC walks every p-bit's bias and
// couplings, then compares the accumulated field against a random sample.
module pbit_sched #(
  parameter int unsigned N_PBITS = 4,
  parameter int unsigned W_PREC  = 6,
  parameter int unsigned ACC_W   = 10,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [7:0]          sweeps,
  input  logic [N_PBITS-1:0]  p_init,
  input  logic [N_PBITS-1:0]  clamp_mask,
  output logic [ADDR_W-1:0]   w_addr,
  input  logic [W_PREC-1:0]   w_data,
  input  logic [ACC_W-1:0]    rnd,
  output logic [N_PBITS-1:0]  p_state,
  output logic                busy,
  output logic                done
);

  localparam int unsigned IDX_W = (N_PBITS > 1) ? $clog2(N_PBITS) : 1;
  localparam int unsigned J_W   = $clog2(N_PBITS + 1);
  localparam int unsigned ROW   = N_PBITS + 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DECIDE, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          i_q, i_d;
  logic [J_W-1:0]            j_q, j_d;
  logic [7:0]                sweep_q, sweep_d;
  logic [7:0]                sweeps_q, sweeps_d;
  logic [N_PBITS-1:0]        clamp_q, clamp_d;
  logic [N_PBITS-1:0]        p_q, p_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [ADDR_W-1:0]         w_addr_q, w_addr_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic signed [W_PREC-1:0]  w_s;
  logic signed [ACC_W-1:0]   rnd_s;
  logic signed [SUM_W-1:0]   w_ext_c, sum_c;
  logic signed [ACC_W-1:0]   acc_sat_c;
  logic                      p_sel_c, last_pbit_c, last_j_c, more_sweeps_c;

  assign w_s           = w_data;
  assign rnd_s         = rnd;
  assign w_ext_c       = SUM_W'(w_s);
  assign last_pbit_c   = (i_q == IDX_W'(N_PBITS - 1));
  assign last_j_c      = (j_q == J_W'(N_PBITS));
  assign more_sweeps_c = (9'(sweep_q) + 9'd1) < 9'(sweeps_q);

  // Sign of the coupling term: bias (j=0) always adds, else follows p_state[j-1]
  always_comb begin
    p_sel_c = 1'b1;
    for (int k = 0; k < int'(N_PBITS); k++) begin
      if (j_q == J_W'(k + 1)) p_sel_c = p_q[k];
    end
  end

  always_comb begin
    sum_c = p_sel_c ? (SUM_W'(acc_q) + w_ext_c) : (SUM_W'(acc_q) - w_ext_c);
    if (sum_c > ACC_MAX)      acc_sat_c = ACC_W'(ACC_MAX);
    else if (sum_c < ACC_MIN) acc_sat_c = ACC_W'(ACC_MIN);
    else                      acc_sat_c = sum_c[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (sweeps == 8'd0) ? S_DONE : S_ACC;
      S_ACC:    if (last_j_c) state_d = S_DECIDE;
      S_DECIDE: state_d = (!last_pbit_c || more_sweeps_c) ? S_ACC : S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath next values and registered outputs
  always_comb begin
    i_d      = i_q;
    j_d      = j_q;
    sweep_d  = sweep_q;
    sweeps_d = sweeps_q;
    clamp_d  = clamp_q;
    p_d      = p_q;
    acc_d    = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          p_d      = p_init;
          sweeps_d = sweeps;
          clamp_d  = clamp_mask;
          i_d      = '0;
          j_d      = '0;
          sweep_d  = '0;
          acc_d    = '0;
        end
      end
      S_ACC: begin
        acc_d = acc_sat_c;
        j_d   = last_j_c ? '0 : j_q + J_W'(1);
      end
      S_DECIDE: begin
        if (!clamp_q[i_q]) p_d[i_q] = (acc_q > rnd_s);
        acc_d = '0;
        j_d   = '0;
        if (!last_pbit_c) begin
          i_d = i_q + IDX_W'(1);
        end else if (more_sweeps_c) begin
          i_d     = '0;
          sweep_d = sweep_q + 8'd1;
        end
      end
      default: ;
    endcase
    w_addr_d = (state_d == S_ACC) ? ADDR_W'(32'(i_d) * ROW + 32'(j_d)) : '0;
    busy_d   = (state_d == S_ACC) || (state_d == S_DECIDE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q      <= '0;
      j_q      <= '0;
      sweep_q  <= '0;
      sweeps_q <= '0;
      clamp_q  <= '0;
      p_q      <= '0;
      acc_q    <= '0;
      w_addr_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      i_q      <= i_d;
      j_q      <= j_d;
      sweep_q  <= sweep_d;
      sweeps_q <= sweeps_d;
      clamp_q  <= clamp_d;
      p_q      <= p_d;
      acc_q    <= acc_d;
      w_addr_q <= w_addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign w_addr  = w_addr_q;
  assign p_state = p_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pbit_sched.sv
// Directed bench for pbit_sched: vector table of whole runs plus hand sequences
// for reset, address stepping, mid-run abort and accumulator saturation.
module tb_pbit_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, busy, done;
  logic [7:0] sweeps;
  logic [3:0] p_init, clamp_mask, p_state;
  logic [4:0] w_addr;
  logic [5:0] w_data;
  logic [9:0] rnd;
  logic [5:0] wmem [32];
  assign w_data = wmem[w_addr];

  pbit_sched u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sweeps(sweeps), .p_init(p_init),
    .clamp_mask(clamp_mask), .w_addr(w_addr), .w_data(w_data), .rnd(rnd),
    .p_state(p_state), .busy(busy), .done(done)
  );

  // Narrow-accumulator instance: every weight +31
  logic       start_s, busy_s, done_s;
  logic [7:0] sweeps_s;
  logic [3:0] p_init_s, clamp_s, p_state_s;
  logic [4:0] w_addr_s;
  logic [5:0] w_data_s;
  logic [6:0] rnd_s;
  assign w_data_s = (w_addr_s < 5'd20) ? 6'd31 : 6'd0;

  pbit_sched #(.N_PBITS(4), .W_PREC(6), .ACC_W(7), .ADDR_W(5)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .sweeps(sweeps_s), .p_init(p_init_s),
    .clamp_mask(clamp_s), .w_addr(w_addr_s), .w_data(w_data_s), .rnd(rnd_s),
    .p_state(p_state_s), .busy(busy_s), .done(done_s)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [3:0] p_init;
    logic [3:0] clamp;
    logic [7:0] sweeps;
    int         bias;
    int         coup;
    int         rnd;
    int         pulse_k;
    logic [3:0] exp_p;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_w(input int bias, input int coup);
    for (int a = 0; a < 32; a++) wmem[a] = (a % 5 == 0) ? 6'(bias) : 6'(coup);
  endtask

  // Launch a run, scramble the launch inputs afterwards, measure latency to done
  task automatic run(input logic [3:0] pi, input logic [3:0] cm, input logic [7:0] sw,
                     input int pulse_k, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    @(negedge clk);
    p_init = pi; clamp_mask = cm; sweeps = sw; start = 1'b1;
    @(negedge clk);
    start = 1'b0; p_init = ~pi; clamp_mask = ~cm; sweeps = 8'd5;
    for (int k = 1; k <= 300; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
      start = (k == pulse_k);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic sat_run(input int rv, input int exp_b0, input string name);
    int seen;
    @(negedge clk);
    rnd_s = 7'(rv); p_init_s = 4'b1111; clamp_s = 4'b0000; sweeps_s = 8'd1; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (6) @(negedge clk);
    chk(name, int'(p_state_s[0]), exp_b0);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done_s) seen = 1;
      else @(negedge clk);
    end
    chk({name, "_done"}, seen, 1);
  endtask

  vec_t vecs[8];
  int   lat, bcnt, seen;
  int   exp_wa[7];

  initial begin
    vecs[0] = '{"bias5",        4'b0000, 4'b0000, 8'd1,  5,  0,  0, 0,  4'b1111, 25};
    vecs[1] = '{"clamp0001",    4'b0000, 4'b0001, 8'd1,  5,  0,  0, 0,  4'b1110, 25};
    vecs[2] = '{"sweeps0",      4'b1010, 4'b0000, 8'd0,  5,  0,  0, 0,  4'b1010, 1};
    vecs[3] = '{"bias_neg_2sw", 4'b1111, 4'b0000, 8'd2, -5,  0,  0, 0,  4'b0000, 49};
    vecs[4] = '{"equal_zero",   4'b1111, 4'b0000, 8'd1,  0,  0,  0, 0,  4'b0000, 25};
    vecs[5] = '{"rnd_neg",      4'b0000, 4'b0000, 8'd1,  0,  0, -1, 0,  4'b1111, 25};
    vecs[6] = '{"coup_seq",     4'b0000, 4'b0000, 8'd1,  1, -3,  0, 0,  4'b0111, 25};
    vecs[7] = '{"start_busy",   4'b1010, 4'b1010, 8'd3, -5,  0,  0, 10, 4'b1010, 73};

    rst_n = 1'b0; start = 1'b1; p_init = 4'b1111; sweeps = 8'd1; clamp_mask = 4'b0000; rnd = '0;
    start_s = 1'b0; p_init_s = '0; sweeps_s = '0; clamp_s = '0; rnd_s = '0;
    set_w(5, 0);

    // Reset held with start asserted
    repeat (4) begin
      @(negedge clk);
      chk("rst_p_state", int'(p_state), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_w_addr", int'(w_addr), 0);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release", int'(busy), 0);

    foreach (vecs[v]) begin
      set_w(vecs[v].bias, vecs[v].coup);
      rnd = 10'(vecs[v].rnd);
      run(vecs[v].p_init, vecs[v].clamp, vecs[v].sweeps, vecs[v].pulse_k, lat, bcnt);
      chk({vecs[v].name, "_latency"}, lat, vecs[v].exp_lat);
      chk({vecs[v].name, "_busy_cycles"}, bcnt, vecs[v].exp_lat - 1);
      chk({vecs[v].name, "_p_state"}, int'(p_state), int'(vecs[v].exp_p));
      @(negedge clk);
      chk({vecs[v].name, "_after_done"}, int'({done, busy, w_addr}), 0);
      chk({vecs[v].name, "_p_hold"}, int'(p_state), int'(vecs[v].exp_p));
    end

    // Weight address stepping across the first p-bit and its DECIDE cycle
    exp_wa = '{0, 1, 2, 3, 4, 0, 5};
    set_w(5, 0);
    rnd = '0;
    @(negedge clk);
    p_init = 4'b0000; clamp_mask = 4'b0000; sweeps = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("w_addr_k%0d", k + 1), int'(w_addr), exp_wa[k]);
      @(negedge clk);
    end
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done) seen = 1;
      else @(negedge clk);
    end
    chk("w_addr_run_done", seen, 1);

    // Reset in the middle of a two-sweep run
    @(negedge clk);
    p_init = 4'b0000; sweeps = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrun_p_before", int'(p_state), 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_busy", int'(busy), 0);
    chk("midrun_p_state", int'(p_state), 0);
    chk("midrun_w_addr", int'(w_addr), 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("midrun_no_done", seen, 0);
    rst_n = 1'b1;
    run(4'b0000, 4'b0000, 8'd2, 0, lat, bcnt);
    chk("after_reset_latency", lat, 49);
    chk("after_reset_p_state", int'(p_state), 15);

    // Saturation at +63 with a 7-bit accumulator
    sat_run(63, 0, "sat_rnd63");
    sat_run(62, 1, "sat_rnd62");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pbit_sched.md
PBIT_SCHED -- requirements
Module: pbit_sched

Interface
REQ-001 Parameter N_PBITS, default 4, number of p-bits sharing the single MAC datapath.
REQ-002 Parameter W_PREC, default 6, signed two's-complement weight/bias width.
REQ-003 Parameter ACC_W, default 10, signed accumulator and random-number width.
REQ-004 Parameter ADDR_W, default 5, weight-address width; must satisfy 2^ADDR_W >= N_PBITS*(N_PBITS+1).
REQ-005 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port start, input, 1, launch request; sampled only in IDLE.
REQ-008 Port sweeps, input, 8, number of full sweeps to run; sampled with start.
REQ-009 Port p_init, input, N_PBITS, initial p-bit states; loaded with start.
REQ-010 Port clamp_mask, input, N_PBITS, 1 = p-bit held at its loaded value; sampled with start.
REQ-011 Port w_addr, output, ADDR_W, weight-memory address = i*(N_PBITS+1)+j.
REQ-012 Port w_data, input, W_PREC, signed weight at w_addr; combinational read, valid in the same cycle.
REQ-013 Port rnd, input, ACC_W, signed random sample; consumed in the DECIDE cycle.
REQ-014 Port p_state, output, N_PBITS, current p-bit states; bit value 1 = +1, bit value 0 = -1.
REQ-015 Port busy, output, 1, high in ACC and DECIDE states.
REQ-016 Port done, output, 1, one-cycle pulse on run completion.

Function
REQ-017 States: IDLE, ACC, DECIDE, DONE; any other encoding returns to IDLE on the next edge.
REQ-018 In IDLE with start=1, the block loads p_state<=p_init and latches sweeps and clamp_mask.
- If sweeps=0, next state is DONE.
- Otherwise, next state is ACC with i=0, j=0, acc=0, sweep counter=0.
REQ-019 Order: p-bits i=0..N_PBITS-1 are updated sequentially within a sweep, with index wrap from N_PBITS-1 back to 0.
REQ-020 ACC lasts N_PBITS+1 cycles per p-bit, j=0..N_PBITS, with w_addr=i*(N_PBITS+1)+j each cycle.
REQ-021 Accumulation by j:
- j=0: acc <= acc + sext(w_data), the bias.
- j>=1: acc <= acc + sext(w_data) when p_state[j-1]=1, else acc - sext(w_data).
- p_state used is the current value, so earlier updates within the sweep are visible.
REQ-022 Each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; there is no wrap-around.
REQ-023 DECIDE lasts one cycle.
- If clamp_mask[i]=0: p_state[i] <= (acc > rnd, signed compare); equality yields 0.
- If clamp_mask[i]=1: p_state[i] is unchanged.
- In both cases acc is cleared.
REQ-024 After DECIDE, the next p-bit or sweep is selected:
- If i<N_PBITS-1: i increments and the block returns to ACC.
- If i=N_PBITS-1 and the sweep counter+1 < sweeps: i=0, the counter increments, and the block returns to ACC.
- Otherwise, next state is DONE.
REQ-025 DONE lasts one cycle with done=1, then the block returns to IDLE; p_state holds its final value until the next start.
REQ-026 Clamped p-bits consume the same cycles as unclamped ones.
- Run latency: start edge to done high = 1 + sweeps*N_PBITS*(N_PBITS+2) cycles.
- For N_PBITS=4 this is 24 cycles per sweep.
REQ-027 start is ignored while busy or in DONE; inputs sampled with start are not re-sampled mid-run.
REQ-028 w_addr is 0 outside ACC.
REQ-029 p_init, sweeps and clamp_mask changes after the start edge have no effect on the current run.

Reset
REQ-030 rst_n low forces, immediately and asynchronously:
- state=IDLE, p_state=0, acc=0, i=0, j=0, sweep counter=0;
- busy=0, done=0, w_addr=0.
REQ-031 Reset asserted mid-run abandons the run with no done pulse; after release the block waits in IDLE for start.

Verification
REQ-032 Reset: drive rst_n=0 with start=1 -> p_state=0000, busy=0, done=0, w_addr=0 throughout; no transition until release.
REQ-033 Single sweep, N_PBITS=4, biases=+5, couplings=0, rnd=0, p_init=0000, sweeps=1 -> busy high 24 cycles, done pulse at cycle 25, p_state=1111.
REQ-034 Clamp: as REQ-033 but clamp_mask=0001 -> p_state=1110, done still at cycle 25.
REQ-035 Saturation with ACC_W=7: bias=+31, all weights=+31, p_init=1111, rnd=+63 -> acc clips at 63, DECIDE yields 0, so p_state[0]=0 after the first p-bit.
REQ-036 Boundaries:
- sweeps=0, p_init=1010 -> done one cycle after start, busy never high, p_state=1010.
- start pulsed while busy -> no effect on the run or its latency.
REQ-037 Mid-run reset: rst_n low at cycle 10 of a 2-sweep run -> busy=0 and p_state=0000 immediately, no done; a new start afterwards completes in 49 cycles.
